bfp_decomp_mc: RTL and testbench
================================

// Module: bfp_decomp_mc
// PURPOSE
// Multi-channel, multi-lane BFP decompressor with full AXI-Stream backpressure. Successor
//   to the single-channel decompressor; sits after the PRB unpacker in the uplink U-plane path.
// Input lanes carry right-aligned mantissas and one exponent per beat. The block produces
//   sign-extended, exponent-scaled, saturated OUT_W samples. Method, IQ width and fs offset
//   are set per channel, and the channel is selected by s_axis_tid.
// PARAMETERS
// LANES    4   samples per beat (I and Q count as separate lanes)
// OUT_W    16  output sample width, signed; also the maximum IQ width
// NUM_CH   4   number of channels; per-channel config width is 4 bits each
// USER_W   32  tuser width
// ID_W     2   tid width, >= clog2(NUM_CH)
// PORTS
// clk                 in   1              clock
// rst                 in   1              synchronous reset, active-high
// s_axis_tdata        in   LANES*OUT_W    mantissa per lane, right-aligned in OUT_W slot
// s_axis_texp         in   4              block exponent for this beat
// s_axis_tid          in   ID_W           channel; sampled on first beat of packet only
// s_axis_tuser        in   USER_W         packet metadata; sampled on first beat only
// s_axis_tvalid/tlast in   1              AXIS valid / end of packet
// s_axis_tready       out  1              AXIS ready
// m_axis_tdata        out  LANES*OUT_W    decompressed samples
// m_axis_tuser        out  USER_W         packet metadata, held constant for the whole packet
// m_axis_tid          out  ID_W           channel of the current packet
// m_axis_tvalid/tlast out  1              AXIS valid / end of packet
// m_axis_tready       in   1              AXIS ready
// ctrl_comp_meth      in   NUM_CH*4       per channel: 1 = BFP; any other value = no compression
// ctrl_iq_width       in   NUM_CH*4       per channel: mantissa width 1..15; 0 means 16
// ctrl_fs_offset      in   NUM_CH*4       per channel: extra left shift added to the exponent
// sat_cnt             out  16             count of saturated lanes; sticks at 0xFFFF
// BEHAVIOUR
// - Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0,
//   m_axis_tid=0, sat_cnt=0. First-beat tracker (sop) = 1.
// - Pipeline: two register stages, each with valid and skid-free ready.
//   - rdy2 = ~v2 | m_axis_tready
//   - rdy1 = ~v1 | rdy2
//   - s_axis_tready = rdy1, combinational from downstream.
//   - Latency is exactly 2 cycles from input handshake to m_axis_tvalid when unstalled.
//   - Throughput is 1 beat per cycle.
// - Stalled output: tdata, tuser, tid and tlast are held stable while tvalid=1 and tready=0.
// - sop: set to 1 after any accepted tlast beat; cleared by any other accepted beat.
// - On an accepted beat with sop=1, the block latches the packet context: tid, tuser, and
//   that channel's meth, iq_width and fs_offset. Control changes mid-packet take effect on
//   the next packet.
// - Stage 1, BFP: w = iq_width (0 -> 16). Each lane is sign-extended from bit w-1 and the
//   bits above w-1 are ignored. shift = texp + fs_offset (5 bits, 0..30).
// - Stage 1, non-BFP: lanes pass through unchanged with shift = 0.
// - Stage 2: y = sext << shift, evaluated at OUT_W+31 bits.
//   - y is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//   - Each lane that clips adds 1 to sat_cnt when it leaves stage 2 (per beat, 0..LANES).
//   - sat_cnt stops at 0xFFFF.
// - Channel range: a tid >= NUM_CH selects channel 0's config, but m_axis_tid still
//   carries the raw tid.
// - Single-beat packet (tlast on first beat): latches context and ends the packet in the
//   same beat.
// - Simultaneous accept and output: a stage may load and drain in the same cycle.
//   No bubble is inserted.
// - Reset mid-packet: both stages are flushed with no partial-packet output. sop=1, so the
//   next accepted beat starts a new packet.
// TESTING
// - ch1 BFP, w=9, fs=0, exp=3, lane=0x1FF -> lane out 0xFFF8 (-1<<3), latency 2 cycles.
// - ch2 non-BFP, tdata lanes 0x1234/0x8000 -> output bit-identical, sat_cnt unchanged.
// - w=8, exp=10, fs=2, lane=0x7F -> out 0x7FFF and sat_cnt +1; lane=0x80 -> out 0x8000, +1.
// - 3-beat packet, tid=1, tuser=0xA5A5A5A5; ctrl_iq_width for ch1 changed after beat 1
//   -> beats 2-3 still use the old width; m_axis_tuser=0xA5A5A5A5 and m_axis_tid=1 on all beats.
// - Random m_axis_tready (50%) with continuous input, 1000 beats -> no loss or duplication,
//   output held stable under stall, full rate when tready=1.
// - Assert rst mid-packet (beat 2 of 4), then a new 2-beat packet on tid=3 -> m_axis_tvalid
//   low the cycle after rst; new packet's tuser and tid taken from its own first beat.

Source files
------------

// File: rtl/bfp_decomp_mc.sv
// Multi-channel, multi-lane BFP decompressor: per-channel method, IQ width and fs offset,
// two-stage AXI-Stream pipeline with full backpressure and a sticky saturation counter.
module bfp_decomp_mc #(
    parameter int LANES  = 4,
    parameter int OUT_W  = 16,
    parameter int NUM_CH = 4,
    parameter int USER_W = 32,
    parameter int ID_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES*OUT_W-1:0] s_axis_tdata,
    input  logic [3:0]             s_axis_texp,
    input  logic [ID_W-1:0]        s_axis_tid,
    input  logic [USER_W-1:0]      s_axis_tuser,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [LANES*OUT_W-1:0] m_axis_tdata,
    output logic [USER_W-1:0]      m_axis_tuser,
    output logic [ID_W-1:0]        m_axis_tid,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    input  logic [NUM_CH*4-1:0]    ctrl_comp_meth,
    input  logic [NUM_CH*4-1:0]    ctrl_iq_width,
    input  logic [NUM_CH*4-1:0]    ctrl_fs_offset,
    output logic [15:0]            sat_cnt
);
    localparam int WIDE  = OUT_W + 31;
    localparam int CNT_W = $clog2(LANES + 1);

    typedef struct packed {
        logic       bfp;
        logic [4:0] width;
        logic [3:0] fs;
    } cfg_t;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic v1;
    logic rdy1;
    logic rdy2;
    logic in_fire;

    assign rdy2          = ~m_axis_tvalid | m_axis_tready;
    assign rdy1          = ~v1 | rdy2;
    assign s_axis_tready = rdy1;
    assign in_fire       = s_axis_tvalid & rdy1;

    // ------------------------------------------------------------------
    // Packet context
    // ------------------------------------------------------------------
    logic              sop;
    cfg_t              live_cfg;
    cfg_t              ctx_cfg;
    cfg_t              eff_cfg;
    logic [ID_W-1:0]   ctx_tid;
    logic [USER_W-1:0] ctx_tuser;
    logic [ID_W-1:0]   eff_tid;
    logic [USER_W-1:0] eff_tuser;
    logic [3:0]        sel_meth;
    logic [3:0]        sel_iq;
    logic [3:0]        sel_fs;

    // Out-of-range channel ids fall through to channel 0's config.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        sel_meth = ctrl_comp_meth[3:0];
        sel_iq   = ctrl_iq_width[3:0];
        sel_fs   = ctrl_fs_offset[3:0];
        for (int c = 1; c < NUM_CH; c++) begin
            if (32'(s_axis_tid) == 32'(c)) begin
                sel_meth = ctrl_comp_meth[c*4 +: 4];
                sel_iq   = ctrl_iq_width[c*4 +: 4];
                sel_fs   = ctrl_fs_offset[c*4 +: 4];
            end
        end
        live_cfg.bfp   = (sel_meth == 4'd1);
        live_cfg.width = (sel_iq == 4'd0) ? 5'(OUT_W) : {1'b0, sel_iq};
        live_cfg.fs    = sel_fs;
    end

    // The first beat of a packet uses the live config; the rest use the latched copy.
    assign eff_cfg   = sop ? live_cfg : ctx_cfg;
    assign eff_tid   = sop ? s_axis_tid : ctx_tid;
    assign eff_tuser = sop ? s_axis_tuser : ctx_tuser;

    always_ff @(posedge clk) begin
        if (rst) begin
            sop <= 1'b1;
        end else if (in_fire) begin
            sop <= s_axis_tlast;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire && sop) begin
            ctx_cfg   <= live_cfg;
            ctx_tid   <= s_axis_tid;
            ctx_tuser <= s_axis_tuser;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: sign extension from the mantissa width, shift amount
    // ------------------------------------------------------------------
    logic [4:0]              sext_sh;
    logic [OUT_W-1:0]        lane_raw [LANES];
    logic [OUT_W-1:0]        lane_up  [LANES];
    logic signed [OUT_W-1:0] lane_sx  [LANES];
    logic [OUT_W-1:0]        sx_d     [LANES];
    logic [4:0]              shift_d;

    assign sext_sh = 5'(OUT_W) - eff_cfg.width;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_raw[l] = s_axis_tdata[l*OUT_W +: OUT_W];
            lane_up[l]  = lane_raw[l] << sext_sh;
            lane_sx[l]  = $signed(lane_up[l]) >>> sext_sh;
            sx_d[l]     = eff_cfg.bfp ? lane_sx[l] : lane_raw[l];
        end
        shift_d = eff_cfg.bfp ? ({1'b0, s_axis_texp} + {1'b0, eff_cfg.fs}) : 5'd0;
    end

    logic [OUT_W-1:0]  s1_sx [LANES];
    logic [4:0]        s1_shift;
    logic              s1_last;
    logic [ID_W-1:0]   s1_tid;
    logic [USER_W-1:0] s1_tuser;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (rdy1) begin
            v1 <= s_axis_tvalid;
        end
    end

    // NOTE: stage-1 payload is left unreset; v1 alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_sx    <= sx_d;
            s1_shift <= shift_d;
            s1_last  <= s_axis_tlast;
            s1_tid   <= eff_tid;
            s1_tuser <= eff_tuser;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: scale, saturate, count clipped lanes
    // ------------------------------------------------------------------
    logic [WIDE-1:0]  wide  [LANES];
    logic [OUT_W-1:0] y_d   [LANES];
    logic [LANES-1:0] clip;
    logic [CNT_W-1:0] clip_cnt;
    logic [16:0]      sat_sum;
    logic [15:0]      sat_next;

    always_comb begin
        clip_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            wide[l] = {{(WIDE-OUT_W){s1_sx[l][OUT_W-1]}}, s1_sx[l]} << s1_shift;
            // In range only when every bit from the output sign bit upward agrees.
            clip[l] = ~(&wide[l][WIDE-1:OUT_W-1]) & (|wide[l][WIDE-1:OUT_W-1]);
            if (clip[l]) begin
                y_d[l] = wide[l][WIDE-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                y_d[l] = wide[l][OUT_W-1:0];
            end
            clip_cnt = clip_cnt + CNT_W'(clip[l]);
        end
    end

    assign sat_sum  = {1'b0, sat_cnt} + 17'(clip_cnt);
    assign sat_next = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tid    <= '0;
            sat_cnt       <= '0;
        end else if (rdy2) begin
            m_axis_tvalid <= v1;
            if (v1) begin
                for (int l = 0; l < LANES; l++) begin
                    m_axis_tdata[l*OUT_W +: OUT_W] <= y_d[l];
                end
                m_axis_tlast <= s1_last;
                m_axis_tuser <= s1_tuser;
                m_axis_tid   <= s1_tid;
                sat_cnt      <= sat_next;
            end
        end
    end

    // A stalled output beat must not change until it is taken.
    property p_stall_hold;
        @(posedge clk) disable iff (rst)
            (m_axis_tvalid && !m_axis_tready) |=>
                m_axis_tvalid && $stable({m_axis_tdata, m_axis_tuser, m_axis_tid, m_axis_tlast});
    endproperty
    assert property (p_stall_hold);

endmodule

// File: tb/tb_bfp_decomp_mc.sv
// Directed bench for bfp_decomp_mc: hand-computed lane vectors, packet context latching,
// backpressure scoreboard and mid-packet reset.
module tb_bfp_decomp_mc;
    localparam int LANES  = 4;
    localparam int OUT_W  = 16;
    localparam int NUM_CH = 4;
    localparam int USER_W = 32;
    localparam int ID_W   = 2;

    typedef struct packed {
        logic [63:0] data;
        logic [31:0] user;
        logic [1:0]  id;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_texp = '0;
    logic [1:0]  s_axis_tid = '0;
    logic [31:0] s_axis_tuser = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [31:0] m_axis_tuser;
    logic [1:0]  m_axis_tid;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [15:0] ctrl_comp_meth = 16'h1011;  // ch3 BFP, ch2 none, ch1 BFP, ch0 BFP
    logic [15:0] ctrl_iq_width  = 16'h8090;  // ch3 8, ch2 16, ch1 9, ch0 16
    logic [15:0] ctrl_fs_offset = 16'h200F;  // ch3 2, ch2 0, ch1 0, ch0 15
    logic [15:0] sat_cnt;

    logic rdy_fixed = 1'b1;
    logic rand_mode = 1'b0;
    logic rnd_bit   = 1'b1;
    assign m_axis_tready = rand_mode ? rnd_bit : rdy_fixed;

    bfp_decomp_mc #(
        .LANES(LANES), .OUT_W(OUT_W), .NUM_CH(NUM_CH), .USER_W(USER_W), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_texp(s_axis_texp), .s_axis_tid(s_axis_tid),
        .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tid(m_axis_tid),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .ctrl_comp_meth(ctrl_comp_meth), .ctrl_iq_width(ctrl_iq_width),
        .ctrl_fs_offset(ctrl_fs_offset), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    int    n_total = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    last_in_cyc = 0;
    int    last_out_cyc = 0;
    int    out_cnt = 0;
    int    exp_pushed = 0;
    beat_t exp_q[$];
    beat_t cur;
    beat_t held;
    logic  held_ok = 1'b0;

    assign cur = {m_axis_tdata, m_axis_tuser, m_axis_tid, m_axis_tlast};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    // Output scoreboard and stall-stability watch, sampled mid-cycle.
    always @(negedge clk) begin
        beat_t w;
        if (rst) begin
            held_ok = 1'b0;
        end else begin
            if (held_ok && m_axis_tvalid) check("stall_hold", cur, held);
            if (m_axis_tvalid && m_axis_tready) begin
                out_cnt++;
                last_out_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("out_count", out_cnt, exp_pushed);
                end else begin
                    w = exp_q.pop_front();
                    check($sformatf("beat%0d", out_cnt), cur, w);
                end
            end
            if (s_axis_tvalid && s_axis_tready) last_in_cyc = cyc;
            held_ok = m_axis_tvalid && !m_axis_tready;
            held    = cur;
        end
    end

    // Entered and left just after a rising edge; holds the beat until accepted.
    task automatic send(input logic [63:0] d, input logic [3:0] e, input logic [1:0] id,
                        input logic [31:0] user, input logic last, input logic [63:0] want_d,
                        input logic [31:0] want_user, input logic [1:0] want_id,
                        input logic expect_out);
        logic acc;
        acc = 1'b0;
        if (expect_out) begin
            exp_q.push_back({want_d, want_user, want_id, last});
            exp_pushed++;
        end
        s_axis_tdata  = d;
        s_axis_texp   = e;
        s_axis_tid    = id;
        s_axis_tuser  = user;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 2000 && !acc; n++) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("accept_wait", acc, 1'b1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 3000 && exp_q.size() != 0; n++) @(posedge clk);
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0;
        int          o0;
        int          left;
        int          pkt;
        logic        first;
        logic [63:0] d;
        logic [31:0] pu;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_tdata", m_axis_tdata, 64'h0);
        check("rst_tuser", m_axis_tuser, 32'h0);
        check("rst_tid", m_axis_tid, 2'd0);
        check("rst_sat", sat_cnt, 16'h0);
        check("rst_tready", s_axis_tready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;

        // ch1 w=9 shift 3: -1, +255, upper bits ignored (0xFE01 -> 1), -256
        send(64'h0100_FE01_00FF_01FF, 4'd3, 2'd1, 32'h1111_0001, 1'b1,
             64'hF800_0008_07F8_FFF8, 32'h1111_0001, 2'd1, 1'b1);
        drain();
        check("latency", last_out_cyc - last_in_cyc, 2);
        check("sat_t1", sat_cnt, 16'd0);

        // ch2 non-BFP: bit-identical pass-through
        send(64'h0001_FFFF_8000_1234, 4'd7, 2'd2, 32'h2222_0002, 1'b1,
             64'h0001_FFFF_8000_1234, 32'h2222_0002, 2'd2, 1'b1);
        drain();
        check("sat_t2", sat_cnt, 16'd0);

        // ch3 w=8 shift 12: 0x7F and 0x80 clip, 0 and 1 do not
        send(64'h0001_0000_0080_007F, 4'd10, 2'd3, 32'h3333_0003, 1'b1,
             64'h1000_0000_8000_7FFF, 32'h3333_0003, 2'd3, 1'b1);
        drain();
        check("sat_t3", sat_cnt, 16'd2);

        // ch3 shift 8: exactly at both rails, no clipping
        send(64'h0040_00FF_0080_007F, 4'd6, 2'd3, 32'h3333_0004, 1'b1,
             64'h4000_FF00_8000_7F00, 32'h3333_0004, 2'd3, 1'b1);
        drain();
        check("sat_edge", sat_cnt, 16'd2);

        // ch0 w=16 (iq 0) shift 30
        send(64'h8000_0001_FFFF_0000, 4'd15, 2'd0, 32'h0000_0005, 1'b1,
             64'h8000_7FFF_8000_0000, 32'h0000_0005, 2'd0, 1'b1);
        drain();
        check("sat_max_shift", sat_cnt, 16'd5);

        // 3-beat ch1 packet; width changed after beat 1, tid/tuser inputs vary mid-packet
        d = 64'h0100_0008_01F8_00F0;
        send(d, 4'd0, 2'd1, 32'hA5A5_A5A5, 1'b0, 64'hFF00_0008_FFF8_00F0, 32'hA5A5_A5A5, 2'd1, 1'b1);
        ctrl_iq_width = 16'h8040;
        send(d, 4'd0, 2'd2, 32'h1234_5678, 1'b0, 64'hFF00_0008_FFF8_00F0, 32'hA5A5_A5A5, 2'd1, 1'b1);
        send(d, 4'd0, 2'd2, 32'h1234_5678, 1'b1, 64'hFF00_0008_FFF8_00F0, 32'hA5A5_A5A5, 2'd1, 1'b1);
        // next packet picks up w=4
        send(d, 4'd0, 2'd1, 32'h3333_0006, 1'b1, 64'h0000_FFF8_FFF8_0000, 32'h3333_0006, 2'd1, 1'b1);
        drain();

        // back-to-back burst with tready high
        c0 = cyc;
        o0 = out_cnt;
        for (int i = 0; i < 20; i++) begin
            d = 64'h0123_4567_89AB_0000 + 64'(i);
            send(d, 4'd0, 2'd2, 32'h4444_0004, 1'(i == 19), d, 32'h4444_0004, 2'd2, 1'b1);
        end
        check("burst_in_rate", cyc - c0, 20);
        drain();
        check("burst_out_lat", last_out_cyc - last_in_cyc, 2);
        check("burst_out_cnt", out_cnt - o0, 20);

        // random backpressure, continuous input, varying packet lengths
        rand_mode = 1'b1;
        o0 = out_cnt;
        left = 0;
        pkt = 0;
        pu = '0;
        for (int i = 0; i < 1000; i++) begin
            d = {$urandom, $urandom};
            first = (left == 0);
            if (first) begin
                left = 1 + (pkt % 4);
                pu = $urandom;
                pkt++;
            end
            left--;
            send(d, 4'(i), 2'd2, first ? pu : $urandom, 1'(left == 0 || i == 999),
                 d, pu, 2'd2, 1'b1);
            if (i == 999) left = 0;
        end
        rand_mode = 1'b0;
        drain();
        check("rand_out_cnt", out_cnt - o0, 1000);

        // reset in the middle of a 4-beat packet while the output is stalled
        rdy_fixed = 1'b0;
        send(64'h1111_2222_3333_4444, 4'd1, 2'd0, 32'h5555_0005, 1'b0, 64'h0, 32'h0, 2'd0, 1'b0);
        send(64'h1111_2222_3333_4444, 4'd1, 2'd0, 32'h5555_0005, 1'b0, 64'h0, 32'h0, 2'd0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_tvalid", m_axis_tvalid, 1'b0);
        check("rst_mid_tdata", m_axis_tdata, 64'h0);
        check("rst_mid_sat", sat_cnt, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_fixed = 1'b1;
        d = 64'h0000_0080_007F_0001;
        send(d, 4'd0, 2'd3, 32'h6666_0006, 1'b0, 64'h0000_FE00_01FC_0004, 32'h6666_0006, 2'd3, 1'b1);
        send(d, 4'd1, 2'd0, 32'h7777_0007, 1'b1, 64'h0000_FC00_03F8_0008, 32'h6666_0006, 2'd3, 1'b1);
        drain();
        check("post_rst_sat", sat_cnt, 16'd0);
        check("post_rst_outs", out_cnt, exp_pushed);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
